// File: rtl/coef_loader_if.sv
// Coefficient stream into the loader: 32-bit data, valid/ready, last.
// master = upstream source, slave = coef_loader.
interface coef_loader_if;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;

  modport master (
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    output s_tready
  );
endinterface

// File: rtl/coef_loader.sv
// Streams one frame of coefficients into TM banks of 2^AW words each.
// Ports: clk, rst (async high), s (stream slave), coef_write* write bus,
// load_done pulse, sticky load_err, busy.
module coef_loader #(
  parameter int COEFW = 18,
  parameter int AW    = 7,
  parameter int TM    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  coef_loader_if.slave            s,
  output logic signed [COEFW-1:0] coef_write,
  output logic [AW-1:0]           coef_write_addr,
  output logic [TM-1:0]           coef_write_en,
  output logic                    load_done,
  output logic                    load_err,
  output logic                    busy
);

  localparam int BW    = (TM > 1) ? $clog2(TM) : 1;
  localparam int NCOEF = TM * (2 ** AW);

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [BW-1:0] BANK_MAX = BW'(TM - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] addr;
  logic [BW-1:0] bank;
  logic          rdy_en;
  logic          ready;
  logic          acc;
  logic          at_end;
  logic          wr;
  logic          err_set;
  logic          err_clr;

  assign acc    = s.s_tvalid && ready;
  assign at_end = (addr == ADDR_MAX) && (bank == BANK_MAX);

  assign s.s_tready = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    wr        = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        // rdy_en holds ready low for the first cycle out of reset
        ready = rdy_en;
        if (acc) begin
          wr      = 1'b1;
          err_clr = 1'b1;
          if (s.s_tlast) begin
            if (NCOEF == 1) state_nx = DONE;
            else            err_set  = 1'b1;
          end else if (NCOEF == 1) begin
            state_nx = FLUSH;
            err_set  = 1'b1;
          end else begin
            state_nx = LOAD;
          end
        end
      end
      LOAD: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (acc) begin
          wr = 1'b1;
          if (at_end) begin
            if (s.s_tlast) begin
              state_nx = DONE;
            end else begin
              state_nx = FLUSH;
              err_set  = 1'b1;
            end
          end else if (s.s_tlast) begin
            state_nx = IDLE;
            err_set  = 1'b1;
          end
        end
      end
      FLUSH: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (acc && s.s_tlast) state_nx = IDLE;
      end
      DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en          <= 1'b0;
      addr            <= '0;
      bank            <= '0;
      coef_write      <= '0;
      coef_write_addr <= '0;
      coef_write_en   <= '0;
      load_err        <= 1'b0;
    end else begin
      rdy_en        <= 1'b1;
      coef_write_en <= wr ? (TM'(1) << bank) : '0;
      if (wr) begin
        coef_write      <= $signed(s.s_tdata[COEFW-1:0]);
        coef_write_addr <= addr;
      end
      // index only survives while the frame continues in LOAD
      if (state_nx != LOAD) begin
        addr <= '0;
        bank <= '0;
      end else if (wr) begin
        if (addr == ADDR_MAX) begin
          addr <= '0;
          bank <= bank + BW'(1);
        end else begin
          addr <= addr + AW'(1);
        end
      end
      if (err_set)      load_err <= 1'b1;
      else if (err_clr) load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coef_loader.sv
// Randomized bench for coef_loader against a frame-level reference model.
// Checks handshake, write bus, done/err/busy every cycle.
module tb_coef_loader;

  localparam int COEFW = 18;
  localparam int AW    = 2;
  localparam int TM    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int NC    = TM * DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coef_loader_if sif ();

  logic signed [COEFW-1:0] coef_write;
  logic [AW-1:0]           coef_write_addr;
  logic [TM-1:0]           coef_write_en;
  logic                    load_done;
  logic                    load_err;
  logic                    busy;

  coef_loader #(
    .COEFW(COEFW),
    .AW   (AW),
    .TM   (TM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s              (sif.slave),
    .coef_write     (coef_write),
    .coef_write_addr(coef_write_addr),
    .coef_write_en  (coef_write_en),
    .load_done      (load_done),
    .load_err       (load_err),
    .busy           (busy)
  );

  int tests = 0;
  int fails = 0;

  // reference model: beats accepted in current frame, plus flags
  int m_pos;
  bit m_done;
  bit m_err;
  bit m_boot;
  int m_addr;
  int m_data;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_done = 0;
    m_err  = 0;
    m_boot = 0;
    m_addr = 0;
    m_data = 0;
  endtask

  task automatic cycle(input bit v, input logic [31:0] d,
                       input bit l, output bit acc);
    int exp_en;
    bit exp_rdy;
    sif.s_tvalid = v;
    sif.s_tdata  = d;
    sif.s_tlast  = l;
    exp_rdy = m_boot && !m_done;
    #1;
    chk("s_tready", 64'(sif.s_tready), 64'(exp_rdy));
    acc    = v && exp_rdy;
    exp_en = 0;
    m_done = 0;
    m_boot = 1;
    if (acc) begin
      if (m_pos == 0) m_err = 0;
      if (m_pos < NC) begin
        exp_en = 1 << (m_pos / DEPTH);
        m_addr = m_pos % DEPTH;
        m_data = int'(d % (32'd1 << COEFW));
      end
      if (l) begin
        if (m_pos == NC - 1) m_done = 1;
        else                 m_err  = 1;
        m_pos = 0;
      end else begin
        if (m_pos == NC - 1) m_err = 1;
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
    chk("write_en",   64'(coef_write_en), 64'(exp_en));
    chk("write_addr", 64'(coef_write_addr), 64'(m_addr));
    chk("write_data", 64'($unsigned(coef_write)), 64'(m_data));
    chk("load_done",  64'(load_done), 64'(m_done));
    chk("load_err",   64'(load_err), 64'(m_err));
    chk("busy",       64'(busy), 64'((m_pos > 0) || m_done));
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0, a);
  endtask

  task automatic beat(input logic [31:0] d, input bit l);
    bit a;
    int n;
    n = 0;
    do begin
      cycle(1'b1, d, l, a);
      n++;
    end while (!a && n < 8);
    chk("accept", 64'(a), 64'd1);
  endtask

  // kind 0: data 1..len; 1: random; 2: 1,0,0 valid pattern; 3: random gaps
  task automatic frame(input int len, input int kind);
    logic [31:0] d;
    for (int i = 0; i < len; i++) begin
      d = (kind == 0) ? 32'(i + 1) : $urandom;
      if (kind == 2 && i > 0) idle(2);
      if (kind == 3) idle($urandom_range(0, 2));
      beat(d, i == len - 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tready", 64'(sif.s_tready), 64'd0);
    chk("rst_en",     64'(coef_write_en), 64'd0);
    chk("rst_data",   64'($unsigned(coef_write)), 64'd0);
    chk("rst_addr",   64'(coef_write_addr), 64'd0);
    chk("rst_done",   64'(load_done), 64'd0);
    chk("rst_err",    64'(load_err), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    sif.s_tvalid = 1'b0;
    sif.s_tdata  = '0;
    sif.s_tlast  = 1'b0;
    model_reset();
    do_reset();
    idle(2);

    frame(NC, 0);
    idle(2);

    beat(32'hFFFE0001, 1'b0);
    chk("sign_trunc", 64'($unsigned(coef_write)), 64'h20001);
    for (int i = 1; i < NC; i++) beat($urandom, i == NC - 1);

    frame(NC, 2);
    idle(1);

    frame(5, 1);
    idle(1);
    frame(NC, 1);

    frame(10, 1);
    idle(2);
    frame(NC, 1);

    frame(1, 1);
    frame(NC, 3);

    for (int f = 0; f < 8; f++) frame($urandom_range(1, NC + 3), 3);
    idle(2);

    frame(3, 1);
    do_reset();
    idle(3);
    frame(NC, 1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coef_loader.md
Name: coef_loader

Overview:
- Upstream feeder for the per-tap coefficient BRAM multiplexers of the FIR.
- Accepts a stream of coefficient words over a valid/ready interface.
- Drives a shared write bus into TM coefficient banks: coefficient index k is written to bank k / 2^AW at address k mod 2^AW.
- Enforces frame length and reports completion and errors to the control logic.

Parameters:
- COEFW, 18: coefficient width in bits; legal range 1..32.
- AW, 7: bank write address width; each bank holds 2^AW coefficients.
- TM, 2: number of coefficient banks (multiplexers); TM >= 1.
- BW (localparam): max(1, clog2(TM)), width of the bank counter.
- NCOEF (localparam): TM * 2^AW, the exact frame length in beats.

Ports:
- clk  in  1  single clock (the banks' write clock).
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  32  coefficient word; only [COEFW-1:0] is used, upper bits are ignored.
- s_tvalid  in  1  input word valid.
- s_tready  out  1  loader can accept a word.
- s_tlast  in  1  marks the final beat of a frame.
- coef_write  out  COEFW  signed coefficient to write.
- coef_write_addr  out  AW  bank write address.
- coef_write_en  out  TM  one-hot bank write enable; bit b selects bank b.
- load_done  out  1  one-cycle pulse when a complete, correct frame has been written.
- load_err  out  1  sticky error flag: malformed frame.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset: all registers clear asynchronously.
  - Outputs after reset: s_tready=0, coef_write=0, coef_write_addr=0, coef_write_en=0, load_done=0, load_err=0, busy=0.
  - State after reset: IDLE. The first cycle after reset deassertion keeps s_tready=0; s_tready goes high from the second cycle.
- Handshake: a beat is accepted on a rising edge where s_tvalid && s_tready. s_tdata must be held while s_tvalid=1 && s_tready=0.
- State IDLE: s_tready=1, busy=0.
  - Accepted beat with s_tlast=0: write index 0, go to LOAD.
  - Accepted beat with s_tlast=1 and NCOEF>1: short frame; write index 0, set load_err, stay IDLE.
- State LOAD: s_tready=1, busy=1. Each accepted beat writes index k = {bank, addr} and the index increments.
  - addr wraps from 2^AW-1 to 0 and increments bank.
  - Accepted beat at k = NCOEF-1 with s_tlast=1: go to DONE.
  - Accepted beat at k = NCOEF-1 with s_tlast=0: go to FLUSH, set load_err.
  - Accepted beat with s_tlast=1 at k < NCOEF-1: that beat is still written; set load_err, go to IDLE. Banks are left partially updated.
- State FLUSH: s_tready=1, busy=1. Accepted beats are discarded (no write enable). An accepted beat with s_tlast=1 goes to IDLE.
- State DONE: exactly one cycle. s_tready=0, busy=1, load_done=1. Then go to IDLE.
- Write timing: registered, one-cycle latency. A beat accepted at edge n produces coef_write, coef_write_addr and coef_write_en (exactly one bit set) valid during cycle n+1.
  - coef_write_en is 0 in every cycle without a writing acceptance.
  - coef_write and coef_write_addr hold their last values when not writing.
- load_done timing: load_done rises in the same cycle that the final write enable is visible. Address/index counters reset to 0 on entry to IDLE.
- load_err: set as above; cleared only by reset or by the next accepted beat taken in IDLE, which starts a new frame.
- Throughput: 1 coefficient per cycle with s_tvalid held high, except the single DONE bubble.
- Bubbles on s_tvalid (s_tvalid=0) leave all state and counters unchanged.
- Reset mid-frame: the frame is abandoned, counters return to 0, and no write enable is asserted during or after reset until a new accepted beat.
- TM=1: bank counter is unused; coef_write_en[0] is asserted on every write.

Test Plan:
Use AW=2, TM=2 (NCOEF=8) and COEFW=18 unless noted.
- Nominal frame: 8 back-to-back beats with data 1..8, s_tlast on beat 8.
  - Bank 0 receives addresses 0..3 = 1..4 and bank 1 receives addresses 0..3 = 5..8, each exactly one cycle after acceptance.
  - load_done pulses once, aligned with the final write; s_tready=0 for exactly that cycle; load_err=0.
- Sign/truncation: beat with s_tdata=32'hFFFE0001 → coef_write=18'h20001; upper bits are ignored.
- Stalled source: s_tvalid toggles 1,0,0,1,... across a full frame → the same writes as nominal with no duplicates or skips; busy stays high from the first beat until DONE.
- Short frame: s_tlast on beat 5 → 5 writes (bank 1 addr 0 last), load_err=1, no load_done. The next 8-beat frame completes normally and clears load_err.
- Long frame: 10 beats, s_tlast on beat 10 → 8 writes only; beats 9–10 dropped; load_err=1; no load_done. Return to IDLE after beat 10.
- Reset mid-frame: assert rst after beat 3 → outputs cleared immediately. After release, a new 8-beat frame starts writing at bank 0 addr 0.
